// File: rtl/iob_2p_fifo_ctrl.sv
// iob_2p_fifo_ctrl
// ----------------
// Synchronous FIFO controller that sits directly in front of iob_2p_mem.
// It owns the read/write pointers, the occupancy counter and full/empty
// status, and steers the memory's write and read ports.
//
// The memory cannot read in a cycle where it writes, so at most one port
// is granted per cycle. When a push and a pop are both eligible, a
// round-robin priority bit decides which one goes, and that bit flips after
// every such contention cycle. Read data appears on the memory output one
// cycle after a pop grant; rdata_valid marks that cycle.
//
// Optional feature: define IOB_2P_FIFO_CTRL_ALMOST_EN to add the AFULL_TH /
// AEMPTY_TH parameters and the registered almost_full / almost_empty outputs.
// The default build (macro undefined) has neither.

module iob_2p_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
`ifdef IOB_2P_FIFO_CTRL_ALMOST_EN
   ,parameter int AFULL_TH  = (2 ** ADDR_W) - 2,
    parameter int AEMPTY_TH = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,

    // producer side
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,

    // consumer side
    input  logic              pop,
    output logic              pop_ready,
    output logic              rdata_valid,

    // status
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
`ifdef IOB_2P_FIFO_CTRL_ALMOST_EN
    output logic              almost_full,
    output logic              almost_empty,
`endif

    // iob_2p_mem control
    output logic              mem_w_en,
    output logic              mem_w_port_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic              mem_r_port_en
);

    // Pointers carry one extra bit beyond the memory address. Equal pointers
    // mean empty; pointers whose low bits match but whose top bits differ
    // mean the writer is exactly one lap ahead, i.e. full.
    localparam logic [ADDR_W:0] LP_ONE = {{ADDR_W{1'b0}}, 1'b1};

`ifdef IOB_2P_FIFO_CTRL_ALMOST_EN
    localparam logic [ADDR_W:0] LP_AFULL_TH  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] LP_AEMPTY_TH = AEMPTY_TH[ADDR_W:0];
`endif

    // state
    logic [ADDR_W:0] r_wptr;
    logic [ADDR_W:0] r_rptr;
    logic [ADDR_W:0] r_level;
    logic            r_prio;
    logic            r_rdataValid;
`ifdef IOB_2P_FIFO_CTRL_ALMOST_EN
    logic            r_almostFull;
    logic            r_almostEmpty;
`endif

    // combinational helpers
    logic            w_full;
    logic            w_empty;
    logic            w_pushElig;
    logic            w_popElig;
    logic            w_contend;
    logic            w_pushGrant;
    logic            w_popGrant;
    logic [ADDR_W:0] w_levelNext;

    // Status is derived purely from the pointers, so it can never disagree
    // with where the pointers actually are.
    always_comb begin
        w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                  (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
        w_empty = (r_wptr == r_rptr);
    end

    // Arbitration: a request is eligible only when the FIFO can honour it;
    // under contention the priority bit picks the winner, otherwise the
    // single eligible request wins outright.
    always_comb begin
        w_pushElig  = push && !w_full;
        w_popElig   = pop && !w_empty;
        w_contend   = w_pushElig && w_popElig;
        w_pushGrant = w_pushElig && (!w_popElig || !r_prio);
        w_popGrant  = w_popElig && (!w_pushElig || r_prio);
    end

    // Next occupancy; the grants are mutually exclusive so at most one
    // adjustment applies. Shared by the level register and the almost flags.
    always_comb begin
        w_levelNext = r_level;
        if (w_pushGrant) begin
            w_levelNext = r_level + LP_ONE;
        end else if (w_popGrant) begin
            w_levelNext = r_level - LP_ONE;
        end
    end

    // Pointer, level, round-robin and read-valid registers; an asynchronous
    // reset drops everything, including a read that is still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_level      <= '0;
            r_prio       <= 1'b0;
            r_rdataValid <= 1'b0;
        end else begin
            if (w_pushGrant) begin
                r_wptr <= r_wptr + LP_ONE;
            end
            if (w_popGrant) begin
                r_rptr <= r_rptr + LP_ONE;
            end
            r_level      <= w_levelNext;
            r_rdataValid <= w_popGrant;
            if (w_contend) begin
                r_prio <= !r_prio;
            end
        end
    end

`ifdef IOB_2P_FIFO_CTRL_ALMOST_EN
    // Almost flags are computed from the next-state level so they change on
    // the same edge as level itself rather than a cycle behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
        end else begin
            r_almostFull  <= (w_levelNext >= LP_AFULL_TH);
            r_almostEmpty <= (w_levelNext <= LP_AEMPTY_TH);
        end
    end

    assign almost_full  = r_almostFull;
    assign almost_empty = r_almostEmpty;
`endif

    // Memory port drive: enables follow the grants; addresses always show
    // the current pointer low bits even when the port is idle.
    always_comb begin
        mem_w_en      = w_pushGrant;
        mem_w_port_en = w_pushGrant;
        mem_w_addr    = r_wptr[ADDR_W-1:0];
        mem_data_in   = push_data;
        mem_r_port_en = w_popGrant;
        mem_r_addr    = r_rptr[ADDR_W-1:0];
    end

    assign push_ready  = w_pushGrant;
    assign pop_ready   = w_popGrant;
    assign rdata_valid = r_rdataValid;
    assign full        = w_full;
    assign empty       = w_empty;
    assign level       = r_level;

endmodule

// File: doc/iob_2p_fifo_ctrl.md
Name: iob_2p_fifo_ctrl

Overview:
- Synchronous FIFO controller placed directly upstream of iob_2p_mem.
- Owns write/read pointers, full/empty status and port arbitration; drives the memory's w_en, w_port_en, w_addr, r_addr and r_port_en.
- The memory performs no read in a cycle where it writes, so this block never issues a write and a read in the same cycle. It arbitrates simultaneous push/pop round-robin and flags when the memory's data_out holds valid pop data.

Parameters:
- DATA_W, 8, data width, passed through to the memory.
- ADDR_W, 6, memory address width; FIFO depth = 2**ADDR_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  producer requests a write of push_data.
- push_data  in  DATA_W  write data.
- push_ready  out  1  push accepted this cycle (combinational).
- pop  in  1  consumer requests a read.
- pop_ready  out  1  pop accepted this cycle (combinational).
- rdata_valid  out  1  memory data_out holds popped word (registered).
- full  out  1  level == 2**ADDR_W.
- empty  out  1  level == 0.
- level  out  ADDR_W+1  current occupancy.
- mem_w_en  out  1  to memory w_en.
- mem_w_port_en  out  1  to memory w_port_en.
- mem_w_addr  out  ADDR_W  to memory w_addr.
- mem_data_in  out  DATA_W  to memory data_in (= push_data).
- mem_r_addr  out  ADDR_W  to memory r_addr.
- mem_r_port_en  out  1  to memory r_port_en.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: wptr=0, rptr=0 (both ADDR_W+1 bits), level=0, prio=0 (write first), rdata_valid=0. Hence empty=1, full=0.
- Eligibility: push_elig = push & ~full; pop_elig = pop & ~empty.
- Grant, both eligible: prio=0 grants push, prio=1 grants pop; prio toggles on every such contention cycle.
- Grant, one eligible: that request is granted; prio is unchanged.
- push_ready = push grant; pop_ready = pop grant. At most one is high per cycle.
- Push grant: mem_w_en = mem_w_port_en = 1, mem_w_addr = wptr[ADDR_W-1:0]; wptr increments and level increments at the next edge.
- Pop grant: mem_r_port_en = 1, mem_r_addr = rptr[ADDR_W-1:0]; rptr increments and level decrements at the next edge.
- No grant: all mem_* enables are 0; addresses still show current pointer low bits.
- Read latency is 1 cycle: rdata_valid is the registered pop grant. The consumer samples memory data_out only while rdata_valid=1; otherwise data_out is Z/stale.
- Pointer wrap: pointers wrap modulo 2**(ADDR_W+1); the MSB distinguishes full from empty.
- full = (wptr[MSB] != rptr[MSB]) & (low bits equal); empty = (wptr == rptr). level is a registered counter that always equals wptr - rptr.
- Full + push: push_ready=0, no state change. Empty + pop: pop_ready=0, rdata_valid=0 next cycle.
- Full and a push/pop in the same cycle: only the pop is eligible, so it is granted.
- Reset mid-operation: all state clears immediately; an in-flight rdata_valid is dropped and memory contents are ignored.

Optional Feature:
- Macro: IOB_2P_FIFO_CTRL_ALMOST_EN.
- When defined: adds parameters AFULL_TH (default 2**ADDR_W-2) and AEMPTY_TH (default 2), plus registered outputs almost_full (level >= AFULL_TH) and almost_empty (level <= AEMPTY_TH). Both are updated from the next-state level, so they are coincident with level; reset values are almost_full=0, almost_empty=1.
- When undefined: those ports and parameters do not exist; all other behaviour is identical.

Test Plan (ADDR_W=2, depth 4):
- Reset then pop=1 -> pop_ready=0, empty=1, rdata_valid stays 0; assert rst mid-burst -> level=0 within the same cycle.
- Push 0xA1,0xA2,0xA3,0xA4 on consecutive cycles -> full=1, level=4; a 5th push -> push_ready=0, mem_w_en=0.
- Pop 4 times -> mem_r_addr 0,1,2,3; rdata_valid one cycle after each pop_ready; data 0xA1..0xA4 in order; empty=1 after the last.
- push=pop=1 with level=2, held 4 cycles -> grants push,pop,push,pop; never both enables high; level ends at 2.
- Run 10 push/pop pairs -> pointers wrap past 7→0, data order preserved, full never set falsely.
- With IOB_2P_FIFO_CTRL_ALMOST_EN (AFULL_TH=3, AEMPTY_TH=1) -> almost_full asserts at level 3, almost_empty deasserts at level 2.
